// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and default frame constants
// used by both the transmit and receive sides.
package uart_pkg;

  localparam int unsigned UART_DATA_BITS    = 8;
  localparam int unsigned UART_CLKS_PER_BIT = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_e;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for an asynchronous input plus one delay flop so the
// consumer can detect edges. Everything resets to 1 (idle level of a UART line).
module uart_rx_sync (
  input  logic clk,
  input  logic rst,
  input  logic rx,
  output logic rx_s,
  output logic rx_d
);

  logic meta_q;
  logic sync_q;
  logic dly_q;

  // Synchronizer chain and edge-detect delay stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      dly_q  <= 1'b1;
    end else begin
      meta_q <= rx;
      sync_q <= meta_q;
      dly_q  <= sync_q;
    end
  end

  assign rx_s = sync_q;
  assign rx_d = dly_q;

endmodule

// File: rtl/uart_receiver.sv
// UART 8N1 receive path with mid-bit sampling. Received bytes are offered on a
// valid/ready holding register; framing errors and overruns pulse for one cycle.
module uart_receiver
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = UART_CLKS_PER_BIT,
  parameter int unsigned DATA_BITS    = UART_DATA_BITS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data,
  output logic                 valid,
  input  logic                 ready,
  output logic                 frame_err,
  output logic                 overrun
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam int unsigned IDX_W = $clog2(DATA_BITS + 1);

  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);

  logic rx_s;
  logic rx_d;

  rx_state_e            state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 frame_err_q, frame_err_d;
  logic                 overrun_q, overrun_d;
  logic                 stop_sample;

  uart_rx_sync u_sync (
    .clk  (clk),
    .rst  (rst),
    .rx   (rx),
    .rx_s (rx_s),
    .rx_d (rx_d)
  );

  // Frame FSM: edge detect, half-bit start check, full-bit data/stop sampling.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    shift_d     = shift_q;
    stop_sample = 1'b0;
    unique case (state_q)
      IDLE: begin
        // Only a fresh falling edge starts a frame; a line stuck low is ignored.
        if (rx_d && !rx_s) begin
          cnt_d   = '0;
          state_d = START;
        end
      end
      START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d = '0;
          if (!rx_s) begin
            idx_d   = '0;
            state_d = DATA;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d = '0;
          for (int unsigned i = 0; i < DATA_BITS; i++) begin
            if (idx_q == IDX_W'(i)) begin
              shift_d[i] = rx_s;
            end
          end
          if (idx_q == IDX_LAST) begin
            state_d = STOP;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      STOP: begin
        // Returning to IDLE mid-stop-bit lets the next start edge be caught.
        if (cnt_q == BIT_LAST) begin
          cnt_d       = '0;
          stop_sample = 1'b1;
          state_d     = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Holding register, consumer handshake and error pulses.
  always_comb begin
    data_d      = data_q;
    valid_d     = valid_q;
    frame_err_d = 1'b0;
    overrun_d   = 1'b0;
    if (valid_q && ready) begin
      valid_d = 1'b0;
    end
    if (stop_sample) begin
      if (rx_s) begin
        // A byte consumed on this same edge frees the register for the new one.
        if (!valid_q || ready) begin
          data_d  = shift_q;
          valid_d = 1'b1;
        end else begin
          overrun_d = 1'b1;
        end
      end else begin
        frame_err_d = 1'b1;
      end
    end
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      shift_q     <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      shift_q     <= shift_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  assign data      = data_q;
  assign valid     = valid_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_uart_receiver.sv
// Bench for uart_receiver: serial frames are scheduled as outcome events at the
// cycle the receiver must resolve them; a frame-level model is checked every cycle.
module tb_uart_receiver;
  import uart_pkg::*;

  localparam int unsigned N = UART_CLKS_PER_BIT;
  localparam int unsigned D = UART_DATA_BITS;
  // Edges from the first low sample (e0) to the stop-bit resolution edge.
  localparam int STOP_LAT = 2 + N / 2 + (D + 1) * N;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         rx = 1'b1;
  logic         ready = 1'b0;
  logic [D-1:0] data;
  logic         valid;
  logic         frame_err;
  logic         overrun;

  uart_receiver #(
    .CLKS_PER_BIT (N),
    .DATA_BITS    (D)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .data      (data),
    .valid     (valid),
    .ready     (ready),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int ready_mode = 0;  // 0 low, 1 high, 2 random, 3 single pulse at pulse_cyc
  int pulse_cyc = -1;

  // Pending frame outcomes keyed by resolution cycle: {stop_ok, byte}.
  logic [D:0]   ev [int];
  logic [D-1:0] m_data = '0;
  logic         m_valid = 1'b0;
  logic         m_fe = 1'b0;
  logic         m_ov = 1'b0;
  logic         old_valid;
  logic [D:0]   cur_ev;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Frame-level reference: apply the resolution event and handshake at each edge.
  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      if (rst) begin
        m_data  = '0;
        m_valid = 1'b0;
        m_fe    = 1'b0;
        m_ov    = 1'b0;
      end else begin
        m_fe      = 1'b0;
        m_ov      = 1'b0;
        old_valid = m_valid;
        if (m_valid && ready) m_valid = 1'b0;
        if (ev.exists(cyc)) begin
          cur_ev = ev[cyc];
          ev.delete(cyc);
          if (cur_ev[D]) begin
            if (!old_valid || ready) begin
              m_data  = cur_ev[D-1:0];
              m_valid = 1'b1;
            end else begin
              m_ov = 1'b1;
            end
          end else begin
            m_fe = 1'b1;
          end
        end
      end
      #1;
      check_eq("valid", valid, m_valid);
      check_eq("data", data, m_data);
      check_eq("frame_err", frame_err, m_fe);
      check_eq("overrun", overrun, m_ov);
    end
  end

  // Consumer ready driver.
  initial begin
    forever begin
      @(negedge clk);
      case (ready_mode)
        0:       ready = 1'b0;
        1:       ready = 1'b1;
        2:       ready = 1'($urandom_range(0, 1));
        default: ready = (cyc + 1 == pulse_cyc);
      endcase
    end
  end

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [D-1:0] b, input logic stop_ok, input logic pulse_on_stop);
    int stop_cyc;
    @(negedge clk);
    rx = 1'b0;
    stop_cyc = cyc + 1 + STOP_LAT;
    ev[stop_cyc] = {stop_ok, b};
    if (pulse_on_stop) begin
      pulse_cyc  = stop_cyc;
      ready_mode = 3;
    end
    repeat (N) @(negedge clk);
    for (int k = 0; k < int'(D); k++) begin
      rx = b[k];
      repeat (N) @(negedge clk);
    end
    rx = stop_ok;
    repeat (N) @(negedge clk);
    rx = 1'b1;
    // A low stop bit needs the line to rise before the next start edge.
    if (!stop_ok) repeat (N / 2) @(negedge clk);
  endtask

  task automatic glitch(input int len);
    @(negedge clk);
    rx = 1'b0;
    repeat (len) @(negedge clk);
    rx = 1'b1;
    repeat (N) @(negedge clk);
  endtask

  task automatic reset_mid_frame(input logic [D-1:0] b);
    @(negedge clk);
    rx = 1'b0;
    repeat (N) @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      rx = b[k];
      repeat (N) @(negedge clk);
    end
    rx = b[4];
    repeat (N / 2) @(negedge clk);
    rst = 1'b1;
    rx  = 1'b1;
    ev.delete();
    #1;
    check_eq("rst_mid_valid", valid, 0);
    check_eq("rst_mid_data", data, 0);
    check_eq("rst_mid_frame_err", frame_err, 0);
    check_eq("rst_mid_overrun", overrun, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    idle(N);
  endtask

  initial begin
    logic [D-1:0] rb;
    logic         rok;
    repeat (3) @(negedge clk);
    check_eq("reset_valid", valid, 0);
    check_eq("reset_data", data, 0);
    check_eq("reset_frame_err", frame_err, 0);
    check_eq("reset_overrun", overrun, 0);
    rst = 1'b0;
    idle(N);

    // Bad stop bit, then a clean frame, then a start glitch followed by a frame.
    ready_mode = 1;
    send_frame(8'h3C, 1'b0, 1'b0);
    idle(4);
    check_eq("ferr_data_kept", data, 0);
    send_frame(8'hA5, 1'b1, 1'b0);
    idle(4);
    check_eq("a5_data", data, 8'hA5);
    glitch(4);
    send_frame(8'h3C, 1'b1, 1'b0);
    idle(4);
    check_eq("after_glitch_data", data, 8'h3C);

    // Overrun with ready held low, then a single-cycle accept.
    ready_mode = 0;
    send_frame(8'h11, 1'b1, 1'b0);
    send_frame(8'h22, 1'b1, 1'b0);
    idle(4);
    check_eq("ovr_data_held", data, 8'h11);
    check_eq("ovr_valid_held", valid, 1);
    pulse_cyc  = cyc + 2;
    ready_mode = 3;
    idle(4);
    ready_mode = 0;
    check_eq("accept_valid", valid, 0);

    // Accept coinciding with the stop-sample edge makes room for the new byte.
    send_frame(8'h11, 1'b1, 1'b0);
    send_frame(8'h22, 1'b1, 1'b1);
    idle(4);
    ready_mode = 0;
    check_eq("same_edge_data", data, 8'h22);
    check_eq("same_edge_valid", valid, 1);

    // Reset during data bit 4, then a normal frame.
    reset_mid_frame(8'hFF);
    send_frame(8'h5A, 1'b1, 1'b0);
    idle(4);
    check_eq("post_rst_data", data, 8'h5A);
    check_eq("post_rst_valid", valid, 1);

    // Randomized frames, stop-bit errors, glitches and consumer stalls.
    ready_mode = 2;
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 9) == 0) glitch(int'($urandom_range(1, 5)));
      rb  = D'($urandom);
      rok = ($urandom_range(0, 7) != 0);
      send_frame(rb, rok, 1'b0);
      idle(int'($urandom_range(0, 3)));
    end
    ready_mode = 1;
    idle(STOP_LAT + 20);
    check_eq("pending_events", ev.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_receiver.md
# uart_receiver

UART receive path: the counterpart to the block that drives the UART `tx` line. It recovers 8N1 frames from an asynchronous serial input `rx` using `CLKS_PER_BIT` clocks per bit and mid-bit sampling. Each received byte is presented on a valid/ready holding register to the uTPU command/data front end. Framing errors and overruns are reported as one-cycle pulses.

## Interface
- `CLKS_PER_BIT`, default 16: clock cycles per serial bit; even, ≥4.
- `DATA_BITS`, default 8: payload bits per frame, LSB first.
- `clk`  in  1: clock.
- `rst`  in  1: reset, asynchronous, active-high.
- `rx`  in  1: serial line, idle high, asynchronous to `clk`.
- `data`  out  DATA_BITS: received byte; stable while `valid`=1.
- `valid`  out  1: `data` holds an unconsumed byte.
- `ready`  in  1: consumer accepts `data` when `valid && ready` at a rising edge.
- `frame_err`  out  1: one-cycle pulse when a stop bit is sampled as 0.
- `overrun`  out  1: one-cycle pulse when a good frame completes while `valid && !ready`.

## Operation
- `rx` passes through a 2-flop synchronizer (`rx_s`), then 1 extra delay flop (`rx_d`) for edge detection. All three flops reset to 1.
- States (`rx_state_e`):
  - IDLE: when `rx_d==1 && rx_s==0` (falling edge), clear the counter and go to START. A line held low without a fresh falling edge never starts a frame (break/error recovery).
  - START: after CLKS_PER_BIT/2 cycles, sample `rx_s`.
    - If 0: go to DATA with bit index 0.
    - If 1: glitch; return to IDLE with no flags.
  - DATA: every CLKS_PER_BIT cycles, sample `rx_s` into the shift register at the current bit index (LSB first). After bit DATA_BITS-1, go to STOP.
  - STOP: after CLKS_PER_BIT cycles, sample `rx_s`, then go to IDLE, which is mid-stop-bit, so back-to-back frames are supported.
    - If 1: good frame.
    - If 0: pulse `frame_err`; the byte is discarded and `data`/`valid` are untouched.
- Good frame outcomes:
  - If `valid==0`, or `valid && ready` in the same cycle: load `data`, set `valid`=1, no overrun.
  - If `valid && !ready`: pulse `overrun`, drop the new byte, keep the old `data`/`valid`.
- `valid` clears on `valid && ready` when no byte lands in that cycle.
- Bit counter width is $clog2(CLKS_PER_BIT); bit index width is $clog2(DATA_BITS+1). There is no wrap beyond those terminal values.

## Timing
- Reset values: `data`=0, `valid`=0, `frame_err`=0, `overrun`=0, state IDLE, counters 0.
- Reset mid-frame abandons the frame; no flag or `valid` is produced.
- Latency: let edge e0 be the first clock edge that samples `rx` low in the first synchronizer flop.
  - State enters START at e0+2.
  - START sample at e0+2+CLKS_PER_BIT/2.
  - Data bit k is sampled at e0+2+CLKS_PER_BIT/2+(k+1)·CLKS_PER_BIT.
  - Stop bit is sampled at e0+2+CLKS_PER_BIT/2+(DATA_BITS+1)·CLKS_PER_BIT. `valid`, `frame_err` or `overrun` are registered at that same edge, i.e. 154 cycles after e0 for the defaults.
- `frame_err` and `overrun` are high for exactly one cycle and are never both high.
- Consumer handshake: zero-latency accept; `valid` deasserts the cycle after `valid && ready`.

## Structure
- Shared package `uart_pkg`:
  - `rx_state_e` (IDLE, START, DATA, STOP; 2-bit enum).
  - Default constants `UART_DATA_BITS`=8 and `UART_CLKS_PER_BIT`=16, also used by the transmit side.
- One sub-module: `uart_rx_sync`, the 2-flop synchronizer plus delay flop. It outputs `rx_s` and `rx_d`, resets to 1, and is reusable for other async inputs.

## Test plan
- Frame 0xA5 with correct stop bit, `ready`=1 → `valid` high for 1 cycle at e0+154, `data`=0xA5, no flags.
- `rx` low 4 cycles then high → no `valid`, no `frame_err`; FSM back in IDLE by e0+11. A following 0x3C frame is received correctly.
- Frame 0x3C with stop bit 0 → `frame_err` 1-cycle pulse at e0+154; `valid`=0, `data`=0.
- Back-to-back 0x11 then 0x22, `ready`=0 → `data`=0x11 held with `valid`=1; `overrun` pulses at the end of the second frame; `data` stays 0x11. Then `ready`=1 for 1 cycle → `valid`=0.
- 0x11 pending, `ready` pulsed exactly on the 0x22 stop-sample edge → `valid` stays 1, `data`=0x22, no `overrun`.
- `rst` asserted during data bit 4 of 0xFF → all outputs 0 immediately. After release, frame 0x5A → `data`=0x5A, `valid`=1.
